// File: rtl/md_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_dbg_pkg
// Description : Register map, response codes and helpers for the MD debug
//               AXI4-Lite bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package md_dbg_pkg;

    localparam logic [5:0] ADDR_CTRL    = 6'h00;
    localparam logic [5:0] ADDR_COMMIT  = 6'h04;
    localparam logic [5:0] ADDR_SNAP    = 6'h08;
    localparam logic [5:0] ADDR_STATUS  = 6'h0C;
    localparam logic [5:0] ADDR_STEP    = 6'h10;
    localparam logic [5:0] ADDR_RST_LEN = 6'h14;
    localparam logic [5:0] ADDR_VERSION = 6'h18;

    localparam int CH_BASE       = 'h40;
    localparam int CH_STRIDE     = 'h40;
    localparam int WORDS_PER_WIN = 8;

    localparam logic [31:0] VERSION_VAL = 32'h4D44_0002;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Ones in bits [width-1:0]; width 256 wraps to all ones.
    function automatic logic [255:0] width_mask(input int width);
        return (256'd1 << width) - 256'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_dbg_rst_pulse.sv
`default_nettype none
// ============================================================================
// Module      : md_dbg_rst_pulse
// Description : Loadable count-down pulse generator; a start reloads the count.
// Revision    : 1.0 - initial release
// ============================================================================
module md_dbg_rst_pulse #(
    parameter int LEN_W = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             pulse
);

    logic [LEN_W-1:0] r_cnt;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= (len == '0) ? LEN_W'(1) : len;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    assign pulse = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/md_dbg_axil_bridge.sv
`default_nettype none
// ============================================================================
// Module      : md_dbg_axil_bridge
// Description : AXI4-Lite debug slave: per-channel wide shadow/commit and
//               snapshot/readback words, plus a programmable core reset pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module md_dbg_axil_bridge
    import md_dbg_pkg::*;
#(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 9,
    parameter int NUM_CH          = 2,
    parameter int DIN_WIDTH       = 210,
    parameter int DOUT_WIDTH      = 192,
    parameter int RST_LEN_W       = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [AXIL_ADDR_WIDTH-1:0]   S_AXIL_AWADDR,
    input  logic                         S_AXIL_AWVALID,
    output logic                         S_AXIL_AWREADY,
    input  logic [AXIL_DATA_WIDTH-1:0]   S_AXIL_WDATA,
    input  logic [AXIL_DATA_WIDTH/8-1:0] S_AXIL_WSTRB,
    input  logic                         S_AXIL_WVALID,
    output logic                         S_AXIL_WREADY,
    output logic [1:0]                   S_AXIL_BRESP,
    output logic                         S_AXIL_BVALID,
    input  logic                         S_AXIL_BREADY,
    input  logic [AXIL_ADDR_WIDTH-1:0]   S_AXIL_ARADDR,
    input  logic                         S_AXIL_ARVALID,
    output logic                         S_AXIL_ARREADY,
    output logic [AXIL_DATA_WIDTH-1:0]   S_AXIL_RDATA,
    output logic [1:0]                   S_AXIL_RRESP,
    output logic                         S_AXIL_RVALID,
    input  logic                         S_AXIL_RREADY,
    output logic [NUM_CH*DIN_WIDTH-1:0]  ch_d_in,
    output logic [NUM_CH-1:0]            ch_write,
    input  logic [NUM_CH*DOUT_WIDTH-1:0] ch_d_out,
    output logic [NUM_CH-1:0]            ch_read,
    input  logic [NUM_CH-1:0]            ch_done,
    input  logic [31:0]                  step,
    output logic                         debug_reset
);

    logic                 r_live, r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic [8:2]           r_awaddr;
    logic [31:0]          r_wdata, r_rdata;
    logic [3:0]           r_wstrb;
    resp_t                r_bresp, r_rresp;
    logic [RST_LEN_W-1:0] r_rst_len;

    logic        w_wr_go, w_wr_glob, w_wr_ok, w_glob_wr, w_commit, w_snap, w_start;
    logic [2:0]  w_wr_ch, w_ar_ch;
    logic [3:0]  w_wr_word, w_ar_word;
    logic [5:0]  w_wr_off, w_ar_off;
    logic        w_ar_glob;
    logic [31:0] w_bmask, w_wdata_m, w_rdata, w_status;
    resp_t       w_rresp;
    logic [31:0] w_ch_rword [8];
    logic [7:0]  w_stale;
    logic        w_unused;

    assign w_unused = &{1'b0, S_AXIL_AWADDR[1:0], S_AXIL_ARADDR[1:0]};

    assign S_AXIL_AWREADY = r_live && !r_aw_held && !r_bvalid;
    assign S_AXIL_WREADY  = r_live && !r_w_held && !r_bvalid;
    assign S_AXIL_ARREADY = r_live && !r_rvalid;
    assign S_AXIL_BVALID  = r_bvalid;
    assign S_AXIL_BRESP   = r_bresp;
    assign S_AXIL_RVALID  = r_rvalid;
    assign S_AXIL_RRESP   = r_rresp;
    assign S_AXIL_RDATA   = r_rdata;

    // Write decode works from the held beats, so it is stable on the go cycle.
    assign w_wr_go   = r_aw_held && r_w_held;
    assign w_wr_glob = (r_awaddr[8:6] == 3'd0);
    assign w_wr_ch   = r_awaddr[8:6] - 3'(CH_BASE / CH_STRIDE);
    assign w_wr_word = r_awaddr[5:2];
    assign w_wr_off  = {r_awaddr[5:2], 2'b00};
    assign w_bmask   = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
    assign w_wdata_m = r_wdata & w_bmask;

    always_comb begin
        w_wr_ok = 1'b0;
        if (w_wr_glob) begin
            case (w_wr_off)
                ADDR_CTRL, ADDR_COMMIT, ADDR_SNAP, ADDR_RST_LEN: w_wr_ok = 1'b1;
                default:                                         w_wr_ok = 1'b0;
            endcase
        end else begin
            w_wr_ok = (int'(w_wr_ch) < NUM_CH) && (int'(w_wr_word) < WORDS_PER_WIN);
        end
    end

    assign w_glob_wr = w_wr_go && w_wr_ok && w_wr_glob;
    assign w_commit  = w_glob_wr && (w_wr_off == ADDR_COMMIT);
    assign w_snap    = w_glob_wr && (w_wr_off == ADDR_SNAP);
    assign w_start   = w_glob_wr && (w_wr_off == ADDR_CTRL) && w_wdata_m[0];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rst_len <= RST_LEN_W'(16);
        end else begin
            r_live <= 1'b1;
            if (S_AXIL_AWVALID && S_AXIL_AWREADY) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= S_AXIL_AWADDR[8:2];
            end
            if (S_AXIL_WVALID && S_AXIL_WREADY) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXIL_WDATA;
                r_wstrb  <= S_AXIL_WSTRB;
            end
            if (w_wr_go) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (w_glob_wr && (w_wr_off == ADDR_RST_LEN)) begin
                    r_rst_len <= (r_rst_len & ~w_bmask[RST_LEN_W-1:0]) | w_wdata_m[RST_LEN_W-1:0];
                end
            end else if (r_bvalid && S_AXIL_BREADY) begin
                r_bvalid <= 1'b0;
            end
            if (S_AXIL_ARVALID && S_AXIL_ARREADY) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
            end else if (r_rvalid && S_AXIL_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign w_ar_glob = (S_AXIL_ARADDR[8:6] == 3'd0);
    assign w_ar_ch   = S_AXIL_ARADDR[8:6] - 3'(CH_BASE / CH_STRIDE);
    assign w_ar_word = S_AXIL_ARADDR[5:2];
    assign w_ar_off  = {S_AXIL_ARADDR[5:2], 2'b00};

    // Eight slots cover every channel index the 9-bit map can address.
    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            localparam logic [255:0] c_din_mask = width_mask(DIN_WIDTH);
            logic [255:0]          r_shadow, r_snap;
            logic [DIN_WIDTH-1:0]  r_d_in;
            logic                  r_write, r_read, r_stale;
            logic                  w_sel;
            logic [31:0]           w_m;

            assign w_sel = w_wr_go && w_wr_ok && !w_wr_glob && (w_wr_ch == 3'(c));
            assign w_m   = w_bmask & c_din_mask[{w_wr_word[2:0], 5'b0} +: 32];

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    r_shadow <= '0;
                    r_snap   <= '0;
                    r_d_in   <= '0;
                    r_write  <= 1'b0;
                    r_read   <= 1'b0;
                    r_stale  <= 1'b0;
                end else begin
                    r_write <= w_commit && w_wdata_m[c];
                    r_read  <= w_snap && w_wdata_m[c];
                    if (w_sel) begin
                        r_shadow[{w_wr_word[2:0], 5'b0} +: 32] <=
                            (r_shadow[{w_wr_word[2:0], 5'b0} +: 32] & ~w_m) | (r_wdata & w_m);
                    end
                    if (w_commit && w_wdata_m[c]) begin
                        r_d_in <= r_shadow[DIN_WIDTH-1:0];
                    end
                    if (w_snap && w_wdata_m[c]) begin
                        r_snap  <= 256'(ch_d_out[c*DOUT_WIDTH +: DOUT_WIDTH]);
                        r_stale <= ~ch_done[c];
                    end
                end
            end

            assign ch_d_in[c*DIN_WIDTH +: DIN_WIDTH] = r_d_in;
            assign ch_write[c]   = r_write;
            assign ch_read[c]    = r_read;
            assign w_stale[c]    = r_stale;
            assign w_ch_rword[c] = w_ar_word[3] ? r_snap[{w_ar_word[2:0], 5'b0} +: 32]
                                                : r_shadow[{w_ar_word[2:0], 5'b0} +: 32];
        end else begin : g_off
            assign w_stale[c]    = 1'b0;
            assign w_ch_rword[c] = '0;
        end
    end

    always_comb begin
        w_status                = '0;
        w_status[NUM_CH-1:0]    = ch_done;
        w_status[15:8]          = w_stale;
        w_status[16]            = debug_reset;
    end

    always_comb begin
        w_rdata = '0;
        w_rresp = RESP_OKAY;
        if (w_ar_glob) begin
            case (w_ar_off)
                ADDR_CTRL, ADDR_COMMIT, ADDR_SNAP: w_rdata = '0;
                ADDR_STATUS:  w_rdata = w_status;
                ADDR_STEP:    w_rdata = step;
                ADDR_RST_LEN: w_rdata = 32'(r_rst_len);
                ADDR_VERSION: w_rdata = VERSION_VAL;
                default:      w_rresp = RESP_SLVERR;
            endcase
        end else if (int'(w_ar_ch) < NUM_CH) begin
            w_rdata = w_ch_rword[w_ar_ch];
        end else begin
            w_rresp = RESP_SLVERR;
        end
    end

    md_dbg_rst_pulse #(
        .LEN_W (RST_LEN_W)
    ) u_rst_pulse (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .start  (w_start),
        .len    (r_rst_len),
        .pulse  (debug_reset)
    );

endmodule
`default_nettype wire

// File: tb/tb_md_dbg_axil_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_dbg_axil_bridge
// Description : Directed self-checking bench for md_dbg_axil_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_dbg_axil_bridge;

    logic         ap_clk = 1'b0;
    logic         ap_rst = 1'b1;
    logic [8:0]   awaddr = '0, araddr = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [419:0] ch_d_in;
    logic [1:0]   ch_write, ch_read;
    logic [383:0] ch_d_out = '0;
    logic [1:0]   ch_done = '0;
    logic [31:0]  step = 32'h0000_1234;
    logic         debug_reset;

    int errors = 0;
    int checks = 0;

    int         wr_cyc = 0, rd_cyc = 0, dr_cyc = 0, dr_rise = 0;
    logic [1:0] wr_seen = '0, rd_seen = '0;
    logic       dr_prev = 1'b0;

    always #5 ap_clk = ~ap_clk;

    md_dbg_axil_bridge dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .S_AXIL_AWADDR  (awaddr),
        .S_AXIL_AWVALID (awvalid),
        .S_AXIL_AWREADY (awready),
        .S_AXIL_WDATA   (wdata),
        .S_AXIL_WSTRB   (wstrb),
        .S_AXIL_WVALID  (wvalid),
        .S_AXIL_WREADY  (wready),
        .S_AXIL_BRESP   (bresp),
        .S_AXIL_BVALID  (bvalid),
        .S_AXIL_BREADY  (bready),
        .S_AXIL_ARADDR  (araddr),
        .S_AXIL_ARVALID (arvalid),
        .S_AXIL_ARREADY (arready),
        .S_AXIL_RDATA   (rdata),
        .S_AXIL_RRESP   (rresp),
        .S_AXIL_RVALID  (rvalid),
        .S_AXIL_RREADY  (rready),
        .ch_d_in        (ch_d_in),
        .ch_write       (ch_write),
        .ch_d_out       (ch_d_out),
        .ch_read        (ch_read),
        .ch_done        (ch_done),
        .step           (step),
        .debug_reset    (debug_reset)
    );

    always @(negedge ap_clk) begin
        if (ch_write != 2'b00) begin
            wr_cyc++;
            wr_seen = wr_seen | ch_write;
        end
        if (ch_read != 2'b00) begin
            rd_cyc++;
            rd_seen = rd_seen | ch_read;
        end
        if (debug_reset) dr_cyc++;
        if (debug_reset && !dr_prev) dr_rise++;
        dr_prev = debug_reset;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, output logic [1:0] resp);
        logic aw_hs, w_hs;
        int   n;
        @(negedge ap_clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge ap_clk);
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        chk("wr_accept", {awvalid, wvalid}, 2'b00);
        awvalid = 1'b0; wvalid = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(negedge ap_clk);
            chk("b_held", bvalid, 1'b1);
            chk("aw_blocked", awready, 1'b0);
        end
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        chk("wr_bvalid", bvalid, 1'b1);
        resp = bresp;
        @(negedge ap_clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [8:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge ap_clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        @(negedge ap_clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        chk("rd_rvalid", rvalid, 1'b1);
        d    = rdata;
        resp = rresp;
        @(negedge ap_clk);
        rready = 1'b0;
    endtask

    logic [31:0]  rd;
    logic [1:0]   rsp;
    logic [209:0] exp_din;
    logic [191:0] snap_pat;

    initial begin
        for (int k = 0; k < 6; k++) snap_pat[k*32 +: 32] = 32'hA5A5_0000 | 32'(k + 1);
        for (int k = 0; k < 6; k++) exp_din[k*32 +: 32] = 32'(32'h1111_1111 * (k + 1));
        exp_din[209:192] = 18'h37777;

        // Reset values
        repeat (3) @(negedge ap_clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_outs", {bvalid, rvalid, wready, arready, debug_reset}, 5'b0);
        chk("rst_din", ch_d_in, 420'd0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);

        axi_read(9'h018, rd, rsp);
        chk("version", rd, 32'h4D44_0002);
        chk("version_resp", rsp, 2'b00);
        axi_read(9'h014, rd, rsp);
        chk("rst_len_default", rd, 32'd16);
        axi_read(9'h010, rd, rsp);
        chk("step_mirror", rd, 32'h0000_1234);

        // Channel 1 shadow fill and commit
        for (int k = 0; k < 7; k++) begin
            axi_write(9'(9'h080 + 4 * k), 32'(32'h1111_1111 * (k + 1)), 4'hF, 0, rsp);
            chk("shadow_wr_resp", rsp, 2'b00);
        end
        axi_read(9'h098, rd, rsp);
        chk("shadow_w6_masked", rd, 32'h0003_7777);
        wr_cyc = 0; wr_seen = '0;
        axi_write(9'h004, 32'h2, 4'hF, 0, rsp);
        repeat (3) @(negedge ap_clk);
        chk("commit_cycles", wr_cyc, 1);
        chk("commit_mask", wr_seen, 2'b10);
        chk("din_ch1", ch_d_in[210 +: 210], exp_din);
        chk("din_ch1_top", ch_d_in[402 +: 18], 18'h37777);
        chk("din_ch0", ch_d_in[0 +: 210], 210'd0);

        wr_cyc = 0;
        axi_write(9'h004, 32'h4, 4'hF, 0, rsp);
        repeat (3) @(negedge ap_clk);
        chk("commit_hi_mask_resp", rsp, 2'b00);
        chk("commit_hi_mask_none", wr_cyc, 0);

        axi_write(9'h040, 32'hDEAD_BEEF, 4'b0011, 0, rsp);
        axi_read(9'h040, rd, rsp);
        chk("wstrb_partial", rd, 32'h0000_BEEF);

        // Snapshot channel 0 while core not done
        ch_d_out = {192'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, snap_pat};
        ch_done  = 2'b00;
        rd_cyc = 0; rd_seen = '0;
        axi_write(9'h008, 32'h1, 4'hF, 0, rsp);
        repeat (3) @(negedge ap_clk);
        chk("snap_cycles", rd_cyc, 1);
        chk("snap_mask", rd_seen, 2'b01);
        ch_d_out = '0;
        for (int k = 0; k < 6; k++) begin
            axi_read(9'(9'h060 + 4 * k), rd, rsp);
            chk("snap_word", rd, snap_pat[k*32 +: 32]);
        end
        axi_read(9'h078, rd, rsp);
        chk("snap_w14_zero", rd, 32'd0);
        axi_write(9'h060, 32'h1234_5678, 4'hF, 0, rsp);
        chk("snap_ro_resp", rsp, 2'b10);
        axi_read(9'h00C, rd, rsp);
        chk("status_stale", rd, 32'h0000_0100);

        ch_done = 2'b01;
        axi_write(9'h008, 32'h1, 4'hF, 0, rsp);
        axi_read(9'h00C, rd, rsp);
        chk("status_fresh", rd, 32'h0000_0001);

        // Debug reset pulse lengths
        axi_write(9'h014, 32'd3, 4'hF, 0, rsp);
        dr_cyc = 0; dr_rise = 0;
        axi_write(9'h000, 32'h1, 4'hF, 0, rsp);
        repeat (10) @(negedge ap_clk);
        chk("dbg_len3", dr_cyc, 3);
        chk("dbg_len3_rise", dr_rise, 1);
        axi_read(9'h000, rd, rsp);
        chk("ctrl_reads_zero", rd, 32'd0);

        axi_write(9'h014, 32'd0, 4'hF, 0, rsp);
        dr_cyc = 0; dr_rise = 0;
        axi_write(9'h000, 32'h1, 4'hF, 0, rsp);
        repeat (10) @(negedge ap_clk);
        chk("dbg_len0", dr_cyc, 1);

        axi_write(9'h014, 32'd6, 4'hF, 0, rsp);
        dr_cyc = 0; dr_rise = 0;
        axi_write(9'h000, 32'h1, 4'hF, 0, rsp);
        axi_write(9'h000, 32'h1, 4'hF, 0, rsp);
        repeat (20) @(negedge ap_clk);
        chk("dbg_ext_rise", dr_rise, 1);
        chk("dbg_ext_long", (dr_cyc > 6) && (dr_cyc <= 12), 1'b1);

        // Error responses and held B
        wr_cyc = 0;
        axi_write(9'h180, 32'hFFFF_FFFF, 4'hF, 0, rsp);
        chk("bad_ch_resp", rsp, 2'b10);
        axi_read(9'h180, rd, rsp);
        chk("bad_ch_rresp", rsp, 2'b10);
        chk("bad_ch_rdata", rd, 32'd0);
        axi_read(9'h01C, rd, rsp);
        chk("unmapped_rresp", rsp, 2'b10);
        axi_write(9'h010, 32'hFFFF_FFFF, 4'hF, 10, rsp);
        chk("step_ro_resp", rsp, 2'b10);
        axi_read(9'h010, rd, rsp);
        chk("step_unchanged", rd, 32'h0000_1234);
        axi_write(9'h014, 32'd9, 4'hF, 0, rsp);
        chk("rst_len_ok", rsp, 2'b00);
        chk("err_no_strobe", wr_cyc, 0);

        // Reset with AW held and W pending
        wr_cyc = 0;
        @(negedge ap_clk);
        awaddr = 9'h004; awvalid = 1'b1; wdata = 32'h3; wstrb = 4'hF;
        @(negedge ap_clk);
        awvalid = 1'b0;
        ap_rst  = 1'b1;
        @(negedge ap_clk);
        chk("midrst_awready", awready, 1'b0);
        chk("midrst_bvalid", bvalid, 1'b0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("midrst_ready", {awready, wready}, 2'b11);
        chk("midrst_din", ch_d_in, 420'd0);
        axi_read(9'h014, rd, rsp);
        chk("midrst_len16", rd, 32'd16);
        axi_write(9'h014, 32'd5, 4'hF, 0, rsp);
        chk("post_rst_wr_resp", rsp, 2'b00);
        axi_read(9'h014, rd, rsp);
        chk("post_rst_len5", rd, 32'd5);
        chk("midrst_no_strobe", wr_cyc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
